// File: rtl/ltpi_gpio_pkg.sv
// Shared definitions for the LTPI low-latency GPIO input path.
package ltpi_gpio_pkg;

  localparam int unsigned LTPI_LL_GPIO_WIDTH         = 16;
  localparam int unsigned LTPI_GPIO_DEBOUNCE_DEFAULT = 250;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } debounce_state_t;

endpackage : ltpi_gpio_pkg

// File: rtl/ltpi_gpio_debounce_bit.sv
// Single-bit synchronizer plus debounce filter.
// With LTPI_LL_GPIO_DEBOUNCE_EN defined a per-bit counter/FSM accepts a new
// level only after DEBOUNCE_CYCLES consecutive mismatching samples; otherwise
// the synchronized value is registered straight into stable.
module ltpi_gpio_debounce_bit
  import ltpi_gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = LTPI_GPIO_DEBOUNCE_DEFAULT,
  parameter logic        RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic stable
);

  logic sync1;
  logic sync2;

  // Two-flop synchronizer into the LTPI clock domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= RESET_VALUE;
      sync2 <= RESET_VALUE;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

`ifdef LTPI_LL_GPIO_DEBOUNCE_EN

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  debounce_state_t  state;
  debounce_state_t  state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;
  logic             last;
  logic             accept;
  logic             cnt_inc;

  assign mismatch = sync2 ^ stable;
  assign last     = (cnt == CNT_LAST);

  // State register plus the counter/stable datapath it controls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      stable <= RESET_VALUE;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_inc ? cnt + CNT_W'(1) : '0;
      if (accept) begin
        stable <= sync2;
      end
    end
  end

  // Next state: enter COUNT on a fresh mismatch, leave on glitch end or acceptance
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (mismatch && !last) state_nxt = COUNT;
      COUNT:   if (!mismatch || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: IDLE holds cnt at 0, so last in IDLE only occurs when DEBOUNCE_CYCLES is 1
  always_comb begin
    accept  = 1'b0;
    cnt_inc = 1'b0;
    unique case (state)
      IDLE, COUNT: begin
        accept  = mismatch && last;
        cnt_inc = mismatch && !last;
      end
      default: ;
    endcase
  end

`else

  // No filtering: stable tracks the synchronizer output every cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= RESET_VALUE;
    end else begin
      stable <= sync2;
    end
  end

`endif

endmodule : ltpi_gpio_debounce_bit

// File: rtl/ltpi_ll_gpio_in_cond.sv
// Low-latency GPIO input conditioner for the LTPI target.
// Synchronizes and (with LTPI_LL_GPIO_DEBOUNCE_EN) debounces each pin, gates
// the result with link alignment and flags per-bit changes while aligned.
module ltpi_ll_gpio_in_cond
  import ltpi_gpio_pkg::*;
#(
  parameter int unsigned      WIDTH           = LTPI_LL_GPIO_WIDTH,
  parameter int unsigned      DEBOUNCE_CYCLES = LTPI_GPIO_DEBOUNCE_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gpio_pin_in,
  input  logic             aligned,
  output logic [WIDTH-1:0] gpio_out,
  output logic             gpio_change,
  output logic [WIDTH-1:0] change_mask
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] mask_nxt;
  logic             aligned_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ltpi_gpio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (gpio_pin_in[i]),
      .stable  (stable[i])
    );
  end

  // Changes are reported only when aligned in both this and the previous
  // cycle, so alignment edges never raise a pulse
  always_comb begin
    mask_nxt = '0;
    if (aligned && aligned_d) begin
      mask_nxt = stable ^ gpio_out;
    end
  end

  // Alignment-gated output and change flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpio_out    <= RESET_VALUE;
      change_mask <= '0;
      gpio_change <= 1'b0;
      aligned_d   <= 1'b0;
    end else begin
      gpio_out    <= aligned ? stable : RESET_VALUE;
      change_mask <= mask_nxt;
      gpio_change <= |mask_nxt;
      aligned_d   <= aligned;
    end
  end

endmodule : ltpi_ll_gpio_in_cond
